// File: rtl/dense_result_streamer.sv
// Captures one packed result vector and replays it word by word on a valid/ready stream.
// Optional running argmax over the streamed words is enabled with `define DENSE_STREAMER_ARGMAX_EN.
module dense_result_streamer #(
    parameter int NUMS       = 128,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUMS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vec_valid_i,
    output logic                       vec_ready_o,
    input  logic [NUMS*DATA_WIDTH-1:0] vec_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [IDX_W-1:0]           out_idx_o,
    output logic                       out_last_o,
    output logic                       busy_o,
    output logic [IDX_W-1:0]           argmax_o,
    output logic                       argmax_valid_o
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMS - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [NUMS];
    logic                  inXfer, outXfer, lastBeat, streaming;

    assign streaming = (state_q == STREAM);
    assign lastBeat  = (cnt_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_ready_o = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        inXfer      = 1'b0;
        outXfer     = 1'b0;
        case (state_q)
            IDLE: begin
                vec_ready_o = 1'b1;
                if (vec_valid_i) begin
                    inXfer  = 1'b1;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (out_ready_i) begin
                    outXfer = 1'b1;
                    if (lastBeat) state_d = IDLE;
                    else          cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUMS; k++) buf_q[k] <= '0;
        end else if (inXfer) begin
            for (int k = 0; k < NUMS; k++) buf_q[k] <= vec_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Beat outputs are gated by state so they read as zero outside STREAM, including during reset.
    assign out_data_o = streaming ? buf_q[cnt_q] : '0;
    assign out_idx_o  = streaming ? cnt_q : '0;
    assign out_last_o = streaming & lastBeat;

`ifdef DENSE_STREAMER_ARGMAX_EN
    localparam int MAN_W = DATA_WIDTH - 9;

    logic [DATA_WIDTH-1:0] curWord, curKey, maxKey_q;
    logic [IDX_W-1:0]      argmax_q;
    logic                  argValid_q, curNan;

    // Order-preserving key: any real word beats the reset key of zero, so all-NaN leaves index 0.
    assign curWord = buf_q[cnt_q];
    assign curKey  = curWord[DATA_WIDTH-1] ? ~curWord : {1'b1, curWord[DATA_WIDTH-2:0]};
    assign curNan  = (&curWord[DATA_WIDTH-2 -: 8]) & (|curWord[MAN_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maxKey_q   <= '0;
            argmax_q   <= '0;
            argValid_q <= 1'b0;
        end else begin
            argValid_q <= outXfer & lastBeat;
            if (inXfer) begin
                maxKey_q <= '0;
                argmax_q <= '0;
            end else if (outXfer && !curNan && (curKey > maxKey_q)) begin
                maxKey_q <= curKey;
                argmax_q <= cnt_q;
            end
        end
    end

    assign argmax_o       = argmax_q;
    assign argmax_valid_o = argValid_q;
`else
    assign argmax_o       = '0;
    assign argmax_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_dense_result_streamer.sv
// Directed self-checking bench for dense_result_streamer; argmax checks follow DENSE_STREAMER_ARGMAX_EN.
module tb_dense_result_streamer;

    localparam int NUMS = 128;
    localparam int DW   = 32;
    localparam int IW   = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               vec_valid_i;
    logic               vec_ready_o;
    logic [NUMS*DW-1:0] vec_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DW-1:0]      out_data_o;
    logic [IW-1:0]      out_idx_o;
    logic               out_last_o;
    logic               busy_o;
    logic [IW-1:0]      argmax_o;
    logic               argmax_valid_o;

    int checks = 0;
    int errors = 0;
    bit sawArgValid = 1'b0;

    dense_result_streamer #(.NUMS(NUMS), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .vec_valid_i    (vec_valid_i),
        .vec_ready_o    (vec_ready_o),
        .vec_i          (vec_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_idx_o      (out_idx_o),
        .out_last_o     (out_last_o),
        .busy_o         (busy_o),
        .argmax_o       (argmax_o),
        .argmax_valid_o (argmax_valid_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (argmax_valid_o === 1'b1) sawArgValid = 1'b1;

    // Pattern 0: rising positives with NaN, -0 and a denormal; 1: scrambled; 2: argmax NaN/tie; 3: signed zeros.
    function automatic logic [31:0] wordFor(input int which, input int k);
        logic [31:0] w;
        case (which)
            0: begin
                case (k)
                    0:       w = 32'h3FC00000;
                    1:       w = 32'h7FC00001;
                    2:       w = 32'h80000000;
                    3:       w = 32'h00000001;
                    default: w = 32'h3FC00000 + 32'(k) * 32'h0003D70A;
                endcase
            end
            1:       w = 32'hC0000000 ^ (32'(k) << 8) ^ 32'(k);
            2:       w = (k == 5 || k == 9) ? 32'h40400000 : (k == 2) ? 32'h7FC00000 : 32'hBF800000;
            default: w = (k == 3) ? 32'h00000000 : 32'h80000000;
        endcase
        return w;
    endfunction

    task automatic loadVec(input int which);
        for (int k = 0; k < NUMS; k++) vec_i[k*DW +: DW] = wordFor(which, k);
    endtask

    task automatic test_reset;
        rst = 1'b1; vec_valid_i = 1'b0; out_ready_i = 1'b0; vec_i = '0;
        #12;
        checks++;
        if (vec_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_data_o !== '0 || out_idx_o !== '0 ||
            out_last_o !== 1'b0 || busy_o !== 1'b0 || argmax_o !== '0 || argmax_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: vready=%b valid=%b data=%h idx=%0d last=%b busy=%b am=%0d amv=%b, required 1 0 0 0 0 0 0 0",
                     vec_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, argmax_o, argmax_valid_o);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_stream;
        int exp = 0;
        @(negedge clk); loadVec(0); vec_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk); vec_valid_i = 1'b0; vec_i = '1;
        while (exp < NUMS) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== wordFor(0, exp) || out_idx_o !== IW'(exp) ||
                out_last_o !== (exp == NUMS-1) || busy_o !== 1'b1 || vec_ready_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL full_beat: valid=%b data=%h idx=%0d last=%b busy=%b vready=%b, required 1 %h %0d %b 1 0",
                         out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, vec_ready_o, wordFor(0, exp), exp, exp == NUMS-1);
            end
            exp++;
            @(negedge clk);
        end
        checks++;
        if (out_valid_o !== 1'b0 || vec_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_idle_after: valid=%b vready=%b busy=%b, required 0 1 0", out_valid_o, vec_ready_o, busy_o);
        end
`ifdef DENSE_STREAMER_ARGMAX_EN
        checks++;
        if (argmax_valid_o !== 1'b1 || argmax_o !== IW'(127)) begin
            errors++;
            $display("[TB] FAIL full_argmax: amv=%b am=%0d, required 1 127", argmax_valid_o, argmax_o);
        end
        @(negedge clk);
        checks++;
        if (argmax_valid_o !== 1'b0 || argmax_o !== IW'(127)) begin
            errors++;
            $display("[TB] FAIL full_argmax_hold: amv=%b am=%0d, required 0 127", argmax_valid_o, argmax_o);
        end
`endif
    endtask

    task automatic test_random_ready;
        int exp = 0;
        int cyc = 0;
        @(negedge clk); loadVec(1); vec_valid_i = 1'b1;
        @(negedge clk); vec_valid_i = 1'b0; vec_i = '0;
        while (exp < NUMS && cyc < 2000) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== wordFor(1, exp) || out_idx_o !== IW'(exp) ||
                out_last_o !== (exp == NUMS-1)) begin
                errors++;
                $display("[TB] FAIL random_beat: valid=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                         out_valid_o, out_data_o, out_idx_o, out_last_o, wordFor(1, exp), exp, exp == NUMS-1);
            end
            out_ready_i = 1'($urandom_range(0, 1));
            if (out_ready_i) exp++;
            cyc++;
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        checks++;
        if (exp != NUMS || out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_done: beats=%0d valid=%b, required %0d 0", exp, out_valid_o, NUMS);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream;
        int exp = 0;
        @(negedge clk); loadVec(1); vec_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk); vec_valid_i = 1'b0;
        while (exp < 40) begin
            exp++;
            @(negedge clk);
        end
        checks++;
        if (out_idx_o !== IW'(40) || out_data_o !== wordFor(1, 40)) begin
            errors++;
            $display("[TB] FAIL pre_reset_beat: idx=%0d data=%h, required 40 %h", out_idx_o, out_data_o, wordFor(1, 40));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (vec_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_data_o !== '0 || out_idx_o !== '0 ||
            out_last_o !== 1'b0 || busy_o !== 1'b0 || argmax_o !== '0 || argmax_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: vready=%b valid=%b data=%h idx=%0d last=%b busy=%b am=%0d amv=%b, required 1 0 0 0 0 0 0 0",
                     vec_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, argmax_o, argmax_valid_o);
        end
        #2; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || vec_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: valid=%b vready=%b, required 0 1", out_valid_o, vec_ready_o);
        end
        loadVec(0); vec_valid_i = 1'b1;
        @(negedge clk); vec_valid_i = 1'b0;
        exp = 0;
        while (exp < NUMS) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_idx_o !== IW'(exp) || out_data_o !== wordFor(0, exp)) begin
                errors++;
                $display("[TB] FAIL restart_beat: valid=%b idx=%0d data=%h, required 1 %0d %h",
                         out_valid_o, out_idx_o, out_data_o, exp, wordFor(0, exp));
            end
            exp++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int exp = 0;
        @(negedge clk); loadVec(0); vec_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk); loadVec(1);
        while (exp < NUMS) begin
            checks++;
            if (out_valid_o !== 1'b1 || vec_ready_o !== 1'b0 || out_idx_o !== IW'(exp) || out_data_o !== wordFor(0, exp)) begin
                errors++;
                $display("[TB] FAIL b2b_first: valid=%b vready=%b idx=%0d data=%h, required 1 0 %0d %h",
                         out_valid_o, vec_ready_o, out_idx_o, out_data_o, exp, wordFor(0, exp));
            end
            exp++;
            @(negedge clk);
        end
        checks++;
        if (out_valid_o !== 1'b0 || vec_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_bubble: valid=%b vready=%b, required 0 1", out_valid_o, vec_ready_o);
        end
        @(negedge clk); vec_valid_i = 1'b0;
        exp = 0;
        while (exp < NUMS) begin
            checks++;
            if (out_valid_o !== 1'b1 || vec_ready_o !== 1'b0 || out_idx_o !== IW'(exp) || out_data_o !== wordFor(1, exp)) begin
                errors++;
                $display("[TB] FAIL b2b_second: valid=%b vready=%b idx=%0d data=%h, required 1 0 %0d %h",
                         out_valid_o, vec_ready_o, out_idx_o, out_data_o, exp, wordFor(1, exp));
            end
            exp++;
            @(negedge clk);
        end
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: valid=%b busy=%b, required 0 0", out_valid_o, busy_o);
        end
    endtask

`ifdef DENSE_STREAMER_ARGMAX_EN
    task automatic test_argmax(input int which, input int wantIdx);
        int exp = 0;
        int earlyPulses = 0;
        @(negedge clk); loadVec(which); vec_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk); vec_valid_i = 1'b0;
        while (exp < NUMS) begin
            if (argmax_valid_o !== 1'b0) earlyPulses++;
            exp++;
            @(negedge clk);
        end
        checks++;
        if (earlyPulses != 0 || argmax_valid_o !== 1'b1 || argmax_o !== IW'(wantIdx)) begin
            errors++;
            $display("[TB] FAIL argmax_%0d: early=%0d amv=%b am=%0d, required 0 1 %0d", which, earlyPulses, argmax_valid_o, argmax_o, wantIdx);
        end
        @(negedge clk);
        checks++;
        if (argmax_valid_o !== 1'b0 || argmax_o !== IW'(wantIdx)) begin
            errors++;
            $display("[TB] FAIL argmax_hold_%0d: amv=%b am=%0d, required 0 %0d", which, argmax_valid_o, argmax_o, wantIdx);
        end
    endtask
`else
    task automatic test_argmax_disabled;
        checks++;
        if (sawArgValid !== 1'b0 || argmax_o !== '0) begin
            errors++;
            $display("[TB] FAIL argmax_disabled: seen_pulse=%b am=%0d, required 0 0", sawArgValid, argmax_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_stream();
        test_random_ready();
        test_reset_midstream();
        test_back_to_back();
`ifdef DENSE_STREAMER_ARGMAX_EN
        test_argmax(2, 5);
        test_argmax(3, 3);
`else
        test_argmax_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
